// File: rtl/cl_dmem_access.sv
// Data-memory access stage: issues one load/store at a time over a valid/ready
// request channel, waits for load responses, and stalls the pipeline meanwhile.
module cl_dmem_access #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_v_i,
  input  logic              is_load_op_i,
  input  logic              is_store_op_i,
  input  logic              is_mem_op_i,
  input  logic              is_byte_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       store_data_i,
  output logic              dmem_req_v_o,
  input  logic              dmem_req_ready_i,
  output logic              dmem_req_we_o,
  output logic [ADDR_W-1:0] dmem_req_addr_o,
  output logic [31:0]       dmem_req_data_o,
  output logic [3:0]        dmem_req_mask_o,
  input  logic              dmem_resp_v_i,
  input  logic [31:0]       dmem_resp_data_i,
  output logic              stall_o,
  output logic              load_v_o,
  output logic [31:0]       load_data_o,
  output logic              store_done_o,
  output logic              err_misalign_o,
  output logic              err_timeout_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    lane_mask = 4'b0001 << lane;
  endfunction

  // Little-endian byte pick with zero extension; lane 0 is bits 7:0.
  function automatic logic [31:0] lbu_extract(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    lbu_extract = {24'd0, word[7:0]};
      2'd1:    lbu_extract = {24'd0, word[15:8]};
      2'd2:    lbu_extract = {24'd0, word[23:16]};
      2'd3:    lbu_extract = {24'd0, word[31:24]};
      default: lbu_extract = 32'd0;
    endcase
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             byte_r;
  logic [1:0]       lane_r;

  logic start_s;
  logic misalign_s;
  logic go_s;
  logic accept_s;
  logic timeout_hit_s;

  assign start_s       = issue_v_i & is_mem_op_i & (is_load_op_i | is_store_op_i);
  assign misalign_s    = start_s & ~is_byte_op_i & (addr_i[1:0] != 2'b00);
  assign go_s          = (state_r == IDLE) & start_s & ~misalign_s;
  assign accept_s      = dmem_req_v_o & dmem_req_ready_i;
  assign timeout_hit_s = (cnt_r == CNT_LAST);

  assign stall_o = go_s | (state_r == REQ) | (state_r == WAIT_RESP);

  // Access FSM with all request fields, result and status flags registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      cnt_r           <= '0;
      byte_r          <= 1'b0;
      lane_r          <= 2'b00;
      dmem_req_v_o    <= 1'b0;
      dmem_req_we_o   <= 1'b0;
      dmem_req_addr_o <= '0;
      dmem_req_data_o <= 32'd0;
      dmem_req_mask_o <= 4'd0;
      load_v_o        <= 1'b0;
      load_data_o     <= 32'd0;
      store_done_o    <= 1'b0;
      err_misalign_o  <= 1'b0;
      err_timeout_o   <= 1'b0;
    end else begin
      load_v_o     <= 1'b0;
      store_done_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (misalign_s) begin
            err_misalign_o <= 1'b1;
          end else if (go_s) begin
            // A store wins when both load and store decode bits are set.
            dmem_req_v_o    <= 1'b1;
            dmem_req_we_o   <= is_store_op_i;
            dmem_req_addr_o <= {addr_i[ADDR_W-1:2], 2'b00};
            dmem_req_mask_o <= is_byte_op_i ? lane_mask(addr_i[1:0]) : 4'hF;
            dmem_req_data_o <= is_byte_op_i ? {4{store_data_i[7:0]}} : store_data_i;
            byte_r          <= is_byte_op_i;
            lane_r          <= addr_i[1:0];
            cnt_r           <= '0;
            state_r         <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (accept_s) begin
            dmem_req_v_o <= 1'b0;
            cnt_r        <= '0;
            if (dmem_req_we_o) begin
              store_done_o <= 1'b1;
              state_r      <= DONE;
            end else begin
              state_r <= WAIT_RESP;
            end
          end else if (timeout_hit_s) begin
            dmem_req_v_o  <= 1'b0;
            err_timeout_o <= 1'b1;
            if (dmem_req_we_o) begin
              store_done_o <= 1'b1;
            end else begin
              load_v_o    <= 1'b1;
              load_data_o <= 32'd0;
            end
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        WAIT_RESP: begin
          if (dmem_resp_v_i) begin
            load_v_o    <= 1'b1;
            load_data_o <= byte_r ? lbu_extract(dmem_resp_data_i, lane_r) : dmem_resp_data_i;
            state_r     <= DONE;
          end else if (timeout_hit_s) begin
            err_timeout_o <= 1'b1;
            load_v_o      <= 1'b1;
            load_data_o   <= 32'd0;
            state_r       <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          dmem_req_v_o <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule
